// File: rtl/vga_timing_decoder_pkg.sv
// vga_timing_pkg
// Purpose: 1920x1080@60 timing constants shared with the sync generator,
//          derived totals, counter limits and the decoder FSM state type.
// Ports:   none (package).
package vga_timing_pkg;

  localparam int H_ACTIVE_1080P = 1920;
  localparam int H_FP_1080P     = 88;
  localparam int H_SYNC_1080P   = 44;
  localparam int H_BP_1080P     = 148;
  localparam int H_TOTAL_1080P  = H_ACTIVE_1080P + H_FP_1080P + H_SYNC_1080P + H_BP_1080P;

  localparam int V_ACTIVE_1080P = 1080;
  localparam int V_FP_1080P     = 4;
  localparam int V_SYNC_1080P   = 5;
  localparam int V_BP_1080P     = 36;
  localparam int V_TOTAL_1080P  = V_ACTIVE_1080P + V_FP_1080P + V_SYNC_1080P + V_BP_1080P;

  localparam logic [11:0] H_CNT_MAX = 12'hFFF;
  localparam logic [10:0] V_CNT_MAX = 11'h7FF;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } vtd_state_e;

endpackage

// File: rtl/vga_timing_decoder_if.sv
// vga_timing_decoder_if
// Purpose: sync inputs and status/coordinate outputs of the timing decoder.
// Signals: h_sync, v_sync (source -> decoder); locked, de, x_pos, y_pos,
//          h_total_meas, v_total_meas, err_count (decoder -> consumer).
// Modports: master = sync source / status consumer, slave = decoder.
interface vga_timing_decoder_if;
  logic        h_sync;
  logic        v_sync;
  logic        locked;
  logic        de;
  logic [10:0] x_pos;
  logic [10:0] y_pos;
  logic [11:0] h_total_meas;
  logic [10:0] v_total_meas;
  logic [7:0]  err_count;

  modport master (
    output h_sync, v_sync,
    input  locked, de, x_pos, y_pos, h_total_meas, v_total_meas, err_count
  );

  modport slave (
    input  h_sync, v_sync,
    output locked, de, x_pos, y_pos, h_total_meas, v_total_meas, err_count
  );
endinterface

// File: rtl/vga_timing_decoder_edge.sv
// sync_edge_det
// Purpose: registers one sync input and flags its assert/deassert edges
//          relative to the asserted level POL.
// Ports:   clk, reset (sync, active-high), sync_in,
//          assert_p / deassert_p (combinational pulses on the sampling edge).
module sync_edge_det #(
  parameter logic POL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic assert_p,
  output logic deassert_p
);

  logic sync_q, sync_d;

  always_comb sync_d = sync_in;

  // Reset to the deasserted level so a sync already asserted after reset
  // still produces an assert edge.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= ~POL;
    else       sync_q <= sync_d;
  end

  assign assert_p   = (sync_in == POL) && (sync_q != POL);
  assign deassert_p = (sync_in != POL) && (sync_q == POL);

endmodule

// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder
// Purpose: measures line/frame timing from h_sync/v_sync, checks it against
//          the configured mode, regenerates de/x_pos/y_pos and reports lock.
// Ports:   clk_148Mhz (pixel clock), reset (sync, active-high),
//          vid (slave modport: syncs in, status/coordinates out).
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_SEARCH | no frame reference yet; waiting for a v assert edge
// ST_TRACK  | counting consecutive good frames in good_cnt
// ST_LOCKED | timing matches; de enabled, bad frames counted
module vga_timing_decoder
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = H_ACTIVE_1080P,
  parameter int   H_FP        = H_FP_1080P,
  parameter int   H_SYNC      = H_SYNC_1080P,
  parameter int   H_BP        = H_BP_1080P,
  parameter int   V_ACTIVE    = V_ACTIVE_1080P,
  parameter int   V_FP        = V_FP_1080P,
  parameter int   V_SYNC      = V_SYNC_1080P,
  parameter int   V_BP        = V_BP_1080P,
  parameter logic SYNC_POL    = 1'b1,
  parameter int   LOCK_FRAMES = 3
) (
  input  logic                 clk_148Mhz,
  input  logic                 reset,
  vga_timing_decoder_if.slave  vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;

  logic h_as, h_ds, v_as, v_ds;

  sync_edge_det #(.POL(SYNC_POL)) u_h_edge (
    .clk(clk_148Mhz), .reset(reset), .sync_in(vid.h_sync),
    .assert_p(h_as), .deassert_p(h_ds)
  );

  sync_edge_det #(.POL(SYNC_POL)) u_v_edge (
    .clk(clk_148Mhz), .reset(reset), .sync_in(vid.v_sync),
    .assert_p(v_as), .deassert_p(v_ds)
  );

  logic [11:0] h_cnt_q, h_cnt_d, h_pw_q, h_pw_d, h_total_meas_q, h_total_meas_d;
  logic [10:0] v_cnt_q, v_cnt_d, v_pw_q, v_pw_d, v_total_meas_q, v_total_meas_d;
  logic        line_err_q, line_err_d;
  logic [7:0]  good_cnt_q, good_cnt_d, err_count_q, err_count_d;
  vtd_state_e  state_q, state_d;
  logic        de_q, de_d;
  logic [10:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;

  logic [11:0] h_cnt_inc;
  logic [10:0] v_cnt_inc;
  logic        line_bad, frame_ok, win;

  // Measurement datapath. v_cnt_inc already includes a simultaneous h edge,
  // so a v edge aligned with an h edge sees the full line count.
  always_comb begin
    h_cnt_inc      = (h_cnt_q == H_CNT_MAX) ? h_cnt_q : h_cnt_q + 12'd1;
    v_cnt_inc      = (h_as && v_cnt_q != V_CNT_MAX) ? v_cnt_q + 11'd1 : v_cnt_q;
    line_bad       = (h_cnt_inc != 12'(H_TOTAL)) || (h_pw_q != 12'(H_SYNC));
    frame_ok       = !(line_err_q || (h_as && line_bad)) &&
                     (v_cnt_inc == 11'(V_TOTAL)) && (v_pw_q == 11'(V_SYNC));

    h_cnt_d        = h_as ? 12'd0 : h_cnt_inc;
    h_total_meas_d = h_as ? h_cnt_inc : h_total_meas_q;
    h_pw_d         = h_ds ? h_cnt_inc : h_pw_q;
    v_cnt_d        = v_as ? 11'd0 : v_cnt_inc;
    v_total_meas_d = v_as ? v_cnt_inc : v_total_meas_q;
    v_pw_d         = v_ds ? v_cnt_inc : v_pw_q;
    line_err_d     = v_as ? 1'b0 : (line_err_q || (h_as && line_bad));
  end

  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    err_count_d = err_count_q;
    // A saturated h_cnt means the line reference is gone, unless an h edge
    // arrives on this very cycle.
    if (h_cnt_q == H_CNT_MAX && !h_as) begin
      state_d    = ST_SEARCH;
      good_cnt_d = 8'd0;
    end else if (v_as) begin
      case (state_q)
        ST_SEARCH: begin
          state_d    = ST_TRACK;
          good_cnt_d = 8'd0;
        end
        ST_TRACK: begin
          if (frame_ok) begin
            good_cnt_d = good_cnt_q + 8'd1;
            if (good_cnt_d >= 8'(LOCK_FRAMES)) state_d = ST_LOCKED;
          end else begin
            good_cnt_d = 8'd0;
          end
        end
        ST_LOCKED: begin
          if (!frame_ok) begin
            state_d    = ST_TRACK;
            good_cnt_d = 8'd0;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_comb begin
    win     = (h_cnt_q >= 12'(H_START)) && (h_cnt_q < 12'(H_START + H_ACTIVE)) &&
              (v_cnt_q >= 11'(V_START)) && (v_cnt_q < 11'(V_START + V_ACTIVE));
    de_d    = win && (state_q == ST_LOCKED);
    x_pos_d = 11'd0;
    y_pos_d = 11'd0;
    if (win) begin
      x_pos_d = 11'(h_cnt_q - 12'(H_START));
      y_pos_d = v_cnt_q - 11'(V_START);
    end
  end

  always_ff @(posedge clk_148Mhz) begin
    if (reset) begin
      h_cnt_q        <= '0;
      h_pw_q         <= '0;
      h_total_meas_q <= '0;
      v_cnt_q        <= '0;
      v_pw_q         <= '0;
      v_total_meas_q <= '0;
      line_err_q     <= 1'b0;
      good_cnt_q     <= '0;
      err_count_q    <= '0;
      state_q        <= ST_SEARCH;
      de_q           <= 1'b0;
      x_pos_q        <= '0;
      y_pos_q        <= '0;
    end else begin
      h_cnt_q        <= h_cnt_d;
      h_pw_q         <= h_pw_d;
      h_total_meas_q <= h_total_meas_d;
      v_cnt_q        <= v_cnt_d;
      v_pw_q         <= v_pw_d;
      v_total_meas_q <= v_total_meas_d;
      line_err_q     <= line_err_d;
      good_cnt_q     <= good_cnt_d;
      err_count_q    <= err_count_d;
      state_q        <= state_d;
      de_q           <= de_d;
      x_pos_q        <= x_pos_d;
      y_pos_q        <= y_pos_d;
    end
  end

  assign vid.locked       = (state_q == ST_LOCKED);
  assign vid.de           = de_q;
  assign vid.x_pos        = x_pos_q;
  assign vid.y_pos        = y_pos_q;
  assign vid.h_total_meas = h_total_meas_q;
  assign vid.v_total_meas = v_total_meas_q;
  assign vid.err_count    = err_count_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder using a scaled-down mode
// (25 clocks x 12 lines) so whole frames are cheap. A second instance with
// inverted SYNC_POL sees the same positive syncs and must never lock.
module tb_vga_timing_decoder;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4, HT = HA + HF + HS + HB;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int LF = 3;
  localparam int FAULT_Y = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_timing_decoder_if dut_if ();
  vga_timing_decoder_if pol_if ();

  vga_timing_decoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .LOCK_FRAMES(LF)
  ) dut (
    .clk_148Mhz(clk), .reset(reset), .vid(dut_if.slave)
  );

  vga_timing_decoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .LOCK_FRAMES(LF)
  ) dut_pol (
    .clk_148Mhz(clk), .reset(reset), .vid(pol_if.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int gx = 0, gy = 0;
  bit gen_kill = 1'b1;
  bit fault_armed = 1'b0;
  bit pol_lock_seen = 1'b0;
  bit pol_de_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic h, v;
    h = gen_kill ? 1'b0 : (gx < HS);
    v = gen_kill ? 1'b0 : (gy < VS);
    dut_if.h_sync = h;
    pol_if.h_sync = h;
    dut_if.v_sync = v;
    pol_if.v_sync = v;
  endtask

  // Drive the current generator position, clock once, sample, advance.
  task automatic tick();
    int len;
    drive();
    @(posedge clk);
    #1;
    if (pol_if.locked) pol_lock_seen = 1'b1;
    if (pol_if.de)     pol_de_seen   = 1'b1;
    if (!gen_kill) begin
      len = (fault_armed && gy == FAULT_Y) ? HT + 1 : HT;
      if (gx == len - 1) begin
        if (fault_armed && gy == FAULT_Y) fault_armed = 1'b0;
        gx = 0;
        gy = (gy == VT - 1) ? 0 : gy + 1;
      end else begin
        gx++;
      end
    end
  endtask

  // Run until the next tick would drive the start of line y.
  task automatic to_line_start(input int y);
    int n;
    n = 0;
    while (!(gx == 0 && gy == y) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) begin
      n_tests++;
      n_fail++;
      $error("FAIL bound_line_start observed=%0d expected=%0d", gy, y);
    end
  endtask

  initial begin
    int de_cnt;
    bit first_de;
    logic [10:0] first_x, first_y, last_x, last_y;

    dut_if.h_sync = 1'b0; dut_if.v_sync = 1'b0;
    pol_if.h_sync = 1'b0; pol_if.v_sync = 1'b0;

    // Reset state
    repeat (4) tick();
    check("rst_locked", 32'(dut_if.locked), 0);
    check("rst_de",     32'(dut_if.de), 0);
    check("rst_x",      32'(dut_if.x_pos), 0);
    check("rst_y",      32'(dut_if.y_pos), 0);
    check("rst_htm",    32'(dut_if.h_total_meas), 0);
    check("rst_vtm",    32'(dut_if.v_total_meas), 0);
    check("rst_err",    32'(dut_if.err_count), 0);

    // Clean lock: 1st v edge -> TRACK, 2nd..4th judged good -> LOCKED
    reset = 1'b0;
    gen_kill = 1'b0;
    gx = 0; gy = 0;
    tick();
    check("lock_edge1", 32'(dut_if.locked), 0);
    repeat (2) begin
      to_line_start(0);
      tick();
      check("lock_edge23", 32'(dut_if.locked), 0);
    end
    to_line_start(0);
    check("lock_pre4", 32'(dut_if.locked), 0);
    tick();
    check("lock_edge4", 32'(dut_if.locked), 1);
    check("lock_htm",   32'(dut_if.h_total_meas), 32'(HT));
    check("lock_vtm",   32'(dut_if.v_total_meas), 32'(VT));
    check("lock_err",   32'(dut_if.err_count), 0);
    check("pol_htm",    32'(pol_if.h_total_meas), 32'(HT));
    check("pol_vtm",    32'(pol_if.v_total_meas), 32'(VT));

    // Active window over one full locked frame
    de_cnt = 0; first_de = 1'b1;
    first_x = '0; first_y = '0; last_x = '0; last_y = '0;
    repeat (HT * VT) begin
      tick();
      if (dut_if.de) begin
        if (first_de) begin
          first_x = dut_if.x_pos;
          first_y = dut_if.y_pos;
          first_de = 1'b0;
        end
        last_x = dut_if.x_pos;
        last_y = dut_if.y_pos;
        de_cnt++;
      end
    end
    check("win_de_count", 32'(de_cnt), 32'(HA * VA));
    check("win_first_x",  32'(first_x), 0);
    check("win_first_y",  32'(first_y), 0);
    check("win_last_x",   32'(last_x), 32'(HA - 1));
    check("win_last_y",   32'(last_y), 32'(VA - 1));
    check("win_locked",   32'(dut_if.locked), 1);

    // Line-length fault: line 3 lasts HT+1 clocks
    fault_armed = 1'b1;
    to_line_start(FAULT_Y + 1);
    tick();
    check("fault_htm_long", 32'(dut_if.h_total_meas), 32'(HT + 1));
    check("fault_still_locked", 32'(dut_if.locked), 1);
    to_line_start(0);
    check("fault_pre_edge", 32'(dut_if.locked), 1);
    tick();
    check("fault_unlock", 32'(dut_if.locked), 0);
    check("fault_err",    32'(dut_if.err_count), 1);
    check("fault_htm",    32'(dut_if.h_total_meas), 32'(HT));
    check("fault_vtm",    32'(dut_if.v_total_meas), 32'(VT));
    repeat (2) begin
      to_line_start(0);
      tick();
      check("fault_track", 32'(dut_if.locked), 0);
    end
    to_line_start(0);
    tick();
    check("fault_relock", 32'(dut_if.locked), 1);

    // Sync loss: h_cnt saturates after 4095 clocks, SEARCH on the next edge
    gen_kill = 1'b1;
    repeat (4095) tick();
    check("loss_pre_sat", 32'(dut_if.locked), 1);
    tick();
    check("loss_search", 32'(dut_if.locked), 0);
    repeat (904) tick();
    check("loss_de",  32'(dut_if.de), 0);
    check("loss_x",   32'(dut_if.x_pos), 0);
    check("loss_err", 32'(dut_if.err_count), 1);

    // Source returns: relock in 4 v edges, err_count retained
    gen_kill = 1'b0;
    gx = 0; gy = 0;
    tick();
    check("ret_edge1", 32'(dut_if.locked), 0);
    repeat (2) begin
      to_line_start(0);
      tick();
    end
    to_line_start(0);
    tick();
    check("ret_relock", 32'(dut_if.locked), 1);
    check("ret_err",    32'(dut_if.err_count), 1);

    // Mid-frame coordinate: line 7, tick driving gx=11 shows h_cnt=10
    to_line_start(7);
    repeat (12) tick();
    check("mid_de", 32'(dut_if.de), 1);
    check("mid_x",  32'(dut_if.x_pos), 32'(10 - (HS + HB)));
    check("mid_y",  32'(dut_if.y_pos), 32'(7 - (VS + VB)));

    // Reset mid-frame
    reset = 1'b1;
    tick();
    check("mrst_locked", 32'(dut_if.locked), 0);
    check("mrst_de",     32'(dut_if.de), 0);
    check("mrst_x",      32'(dut_if.x_pos), 0);
    check("mrst_y",      32'(dut_if.y_pos), 0);
    check("mrst_htm",    32'(dut_if.h_total_meas), 0);
    check("mrst_vtm",    32'(dut_if.v_total_meas), 0);
    check("mrst_err",    32'(dut_if.err_count), 0);
    reset = 1'b0;
    repeat (3) begin
      to_line_start(0);
      tick();
      check("mrst_track", 32'(dut_if.locked), 0);
    end
    to_line_start(0);
    tick();
    check("mrst_relock", 32'(dut_if.locked), 1);
    check("mrst_err_after", 32'(dut_if.err_count), 0);

    // Inverted polarity instance never locks
    check("pol_never_locked", 32'(pol_lock_seen), 0);
    check("pol_never_de",     32'(pol_de_seen), 0);
    check("pol_err",          32'(pol_if.err_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
